// File: rtl/bp_pkg.sv
// Shared definitions for the local branch-predictor table and its port scheduler.
package bp_pkg;

   localparam int unsigned IDXW = 7;
   localparam int unsigned TAGW = 23;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      DRAIN  = 2'd1,
      ACK    = 2'd2
   } sched_state_e;

endpackage

// File: rtl/bp_upd_fifo.sv
// Register FIFO of resolved branch updates; exposes the head entry, the
// occupancy and a per-slot index match against the fetch lookup index.
module bp_upd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDXW  = bp_pkg::IDXW,
   parameter int unsigned TAGW  = bp_pkg::TAGW,
   localparam int unsigned PTRW = $clog2(DEPTH),
   localparam int unsigned CNTW = PTRW + 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            push,
   input  logic [IDXW-1:0] push_index,
   input  logic [TAGW-1:0] push_tag,
   input  logic            push_taken,
   input  logic            push_alloc,
   input  logic [31:0]     push_target,
   input  logic            pop,
   input  logic [IDXW-1:0] cmp_index,
   output logic [IDXW-1:0] head_index,
   output logic [TAGW-1:0] head_tag,
   output logic            head_taken,
   output logic            head_alloc,
   output logic [31:0]     head_target,
   output logic [CNTW-1:0] count,
   output logic [DEPTH-1:0] match
);

   logic [IDXW-1:0] idx_q    [DEPTH];
   logic [TAGW-1:0] tag_q    [DEPTH];
   logic            taken_q  [DEPTH];
   logic            alloc_q  [DEPTH];
   logic [31:0]     target_q [DEPTH];
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;
   logic            do_pop;

   assign do_pop = pop && (count != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTRW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PTRW'(1);
         count <= count + CNTW'(push) - CNTW'(do_pop);
      end
   end

   // Payload storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         idx_q[wr_ptr]    <= push_index;
         tag_q[wr_ptr]    <= push_tag;
         taken_q[wr_ptr]  <= push_taken;
         alloc_q[wr_ptr]  <= push_alloc;
         target_q[wr_ptr] <= push_target;
      end
   end

   assign head_index  = idx_q[rd_ptr];
   assign head_tag    = tag_q[rd_ptr];
   assign head_taken  = taken_q[rd_ptr];
   assign head_alloc  = alloc_q[rd_ptr];
   assign head_target = target_q[rd_ptr];

   for (genvar g = 0; g < DEPTH; g++) begin : g_match
      logic [PTRW-1:0] rel;
      assign rel      = PTRW'(g) - rd_ptr;
      assign match[g] = (CNTW'(rel) < count) && (idx_q[g] == cmp_index);
   end

endmodule

// File: rtl/bp_port_sched.sv
// Arbitrates the single branch-predictor table port between fetch lookups
// and queued decode updates, with a drain handshake for table maintenance.
module bp_port_sched import bp_pkg::*; #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDXW  = bp_pkg::IDXW,
   parameter int unsigned TAGW  = bp_pkg::TAGW
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            lk_req,
   input  logic [IDXW-1:0] lk_index,
   output logic            lk_grant,
   output logic            stall_f,
   input  logic            upd_valid,
   input  logic [IDXW-1:0] upd_index,
   input  logic [TAGW-1:0] upd_tag,
   input  logic            upd_taken,
   input  logic            upd_hit,
   input  logic [31:0]     upd_target,
   output logic            tbl_en,
   output logic            tbl_we,
   output logic [IDXW-1:0] tbl_index,
   output logic            tbl_alloc,
   output logic            tbl_taken,
   output logic [TAGW-1:0] tbl_wtag,
   output logic [31:0]     tbl_wtarget,
   input  logic            sync_req,
   output logic            sync_ack,
   output logic [15:0]     deny_cnt
);

   localparam int unsigned CNTW = $clog2(DEPTH) + 1;
   localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

   sched_state_e     state;
   logic [IDXW-1:0]  head_index;
   logic [TAGW-1:0]  head_tag;
   logic             head_taken;
   logic             head_alloc;
   logic [31:0]      head_target;
   logic [CNTW-1:0]  count;
   logic [DEPTH-1:0] match;
   logic             conflict_c;
   logic             grant_c;
   logic             pop_c;

   bp_upd_fifo #(.DEPTH(DEPTH), .IDXW(IDXW), .TAGW(TAGW)) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .push        (upd_valid),
      .push_index  (upd_index),
      .push_tag    (upd_tag),
      .push_taken  (upd_taken),
      .push_alloc  (~upd_hit),
      .push_target (upd_target),
      .pop         (pop_c),
      .cmp_index   (lk_index),
      .head_index  (head_index),
      .head_tag    (head_tag),
      .head_taken  (head_taken),
      .head_alloc  (head_alloc),
      .head_target (head_target),
      .count       (count),
      .match       (match)
   );

   // A lookup must not read an index that still has an update in flight.
   assign conflict_c = lk_req && ((|match) || (upd_valid && (upd_index == lk_index)));

   always_comb begin
      grant_c = 1'b0;
      pop_c   = 1'b0;
      case (state)
         NORMAL: begin
            if (count == FULL)                 pop_c   = 1'b1;
            else if (lk_req && !conflict_c)    grant_c = 1'b1;
            else if (count != '0)              pop_c   = 1'b1;
         end
         DRAIN:   pop_c = (count != '0);
         default: ;
      endcase
   end

   assign lk_grant    = grant_c;
   assign stall_f     = lk_req && !grant_c;
   assign tbl_en      = grant_c || pop_c;
   assign tbl_we      = pop_c;
   assign tbl_index   = pop_c ? head_index : (grant_c ? lk_index : '0);
   assign tbl_alloc   = pop_c && head_alloc;
   assign tbl_taken   = pop_c && head_taken;
   assign tbl_wtag    = pop_c ? head_tag : '0;
   assign tbl_wtarget = pop_c ? head_target : '0;

   // Drain handshake FSM; sync_ack is high exactly while in ACK.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= NORMAL;
         sync_ack <= 1'b0;
         deny_cnt <= '0;
      end else begin
         if (stall_f && (deny_cnt != 16'hFFFF)) deny_cnt <= deny_cnt + 16'd1;
         case (state)
            NORMAL: begin
               sync_ack <= 1'b0;
               if (sync_req) state <= DRAIN;
            end
            DRAIN: begin
               if ((count == '0) && !upd_valid) begin
                  state    <= ACK;
                  sync_ack <= 1'b1;
               end
            end
            ACK: begin
               state    <= NORMAL;
               sync_ack <= 1'b0;
            end
            default: begin
               state    <= NORMAL;
               sync_ack <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bp_port_sched.sv
// Directed bench for bp_port_sched: arbitration, hazards, full-queue
// behaviour, drain handshake and reset during drain.
module tb_bp_port_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        lk_req;
   logic [6:0]  lk_index;
   logic        lk_grant;
   logic        stall_f;
   logic        upd_valid;
   logic [6:0]  upd_index;
   logic [22:0] upd_tag;
   logic        upd_taken;
   logic        upd_hit;
   logic [31:0] upd_target;
   logic        tbl_en;
   logic        tbl_we;
   logic [6:0]  tbl_index;
   logic        tbl_alloc;
   logic        tbl_taken;
   logic [22:0] tbl_wtag;
   logic [31:0] tbl_wtarget;
   logic        sync_req;
   logic        sync_ack;
   logic [15:0] deny_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   bp_port_sched #(.DEPTH(4), .IDXW(7), .TAGW(23)) dut (
      .clk(clk), .reset_n(reset_n),
      .lk_req(lk_req), .lk_index(lk_index), .lk_grant(lk_grant), .stall_f(stall_f),
      .upd_valid(upd_valid), .upd_index(upd_index), .upd_tag(upd_tag),
      .upd_taken(upd_taken), .upd_hit(upd_hit), .upd_target(upd_target),
      .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_index(tbl_index), .tbl_alloc(tbl_alloc),
      .tbl_taken(tbl_taken), .tbl_wtag(tbl_wtag), .tbl_wtarget(tbl_wtarget),
      .sync_req(sync_req), .sync_ack(sync_ack), .deny_cnt(deny_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic v, input logic [6:0] idx, input logic [22:0] tag,
                      input logic taken, input logic hit, input logic [31:0] tgt);
      upd_valid  = v;
      upd_index  = idx;
      upd_tag    = tag;
      upd_taken  = taken;
      upd_hit    = hit;
      upd_target = tgt;
   endtask

   initial begin
      reset_n  = 1'b0;
      lk_req   = 1'b1;
      lk_index = 7'd5;
      sync_req = 1'b0;
      upd(1'b0, 7'd0, 23'd0, 1'b0, 1'b0, 32'd0);
      #2;
      // reset with a pending lookup and an empty queue
      chk("rst_grant", lk_grant, 1);
      chk("rst_en", tbl_en, 1);
      chk("rst_we", tbl_we, 0);
      chk("rst_index", tbl_index, 5);
      chk("rst_stall", stall_f, 0);
      chk("rst_ack", sync_ack, 0);
      chk("rst_deny", deny_cnt, 0);
      tick();
      tick();
      reset_n = 1'b1;
      lk_req  = 1'b0;
      #1;
      chk("idle_en", tbl_en, 0);
      chk("idle_grant", lk_grant, 0);
      tick();

      // single allocate update, written the cycle after the push
      upd(1'b1, 7'd9, 23'h1234, 1'b1, 1'b0, 32'h40);
      #1;
      chk("nobypass_en", tbl_en, 0);
      tick();
      upd(1'b0, 7'd0, 23'd0, 1'b0, 1'b0, 32'd0);
      #1;
      chk("alloc_we", tbl_we, 1);
      chk("alloc_alloc", tbl_alloc, 1);
      chk("alloc_index", tbl_index, 9);
      chk("alloc_target", tbl_wtarget, 32'h40);
      chk("alloc_tag", tbl_wtag, 23'h1234);
      chk("alloc_taken", tbl_taken, 1);
      tick();
      chk("alloc_drained", tbl_en, 0);

      // same-index hazard: queued update written before the lookup
      upd(1'b1, 7'd12, 23'h77, 1'b0, 1'b1, 32'h80);
      tick();
      upd(1'b0, 7'd0, 23'd0, 1'b0, 1'b0, 32'd0);
      lk_req   = 1'b1;
      lk_index = 7'd12;
      #1;
      chk("haz_stall", stall_f, 1);
      chk("haz_grant", lk_grant, 0);
      chk("haz_we", tbl_we, 1);
      chk("haz_index", tbl_index, 12);
      chk("haz_alloc", tbl_alloc, 0);
      tick();
      chk("haz_grant2", lk_grant, 1);
      chk("haz_we2", tbl_we, 0);
      chk("haz_index2", tbl_index, 12);
      chk("haz_deny", deny_cnt, 1);

      // fill the queue under non-conflicting lookups, then push while full
      lk_index = 7'd3;
      for (int i = 0; i < 4; i++) begin
         upd(1'b1, 7'(20 + i), 23'(i), 1'b1, 1'(i % 2), 32'(256 + i));
         #1;
         chk("fill_grant", lk_grant, 1);
         tick();
      end
      upd(1'b1, 7'd24, 23'd4, 1'b1, 1'b0, 32'd260);
      #1;
      chk("full_grant", lk_grant, 0);
      chk("full_stall", stall_f, 1);
      chk("full_index", tbl_index, 20);
      chk("full_alloc", tbl_alloc, 1);
      tick();
      upd(1'b0, 7'd0, 23'd0, 1'b0, 1'b0, 32'd0);
      #1;
      chk("full2_grant", lk_grant, 0);
      chk("full2_index", tbl_index, 21);
      chk("full2_alloc", tbl_alloc, 0);
      tick();
      lk_req = 1'b0;
      for (int i = 2; i < 5; i++) begin
         #1;
         chk("order_we", tbl_we, 1);
         chk("order_index", tbl_index, 7'(20 + i));
         chk("order_target", tbl_wtarget, 32'(256 + i));
         tick();
      end
      chk("order_empty", tbl_en, 0);
      chk("order_deny", deny_cnt, 3);

      // drain handshake with three queued entries
      lk_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         upd(1'b1, 7'(30 + i), 23'd0, 1'b0, 1'b1, 32'd0);
         tick();
      end
      upd(1'b0, 7'd0, 23'd0, 1'b0, 1'b0, 32'd0);
      sync_req = 1'b1;
      #1;
      chk("sync_req_grant", lk_grant, 1);
      tick();
      sync_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("drain_grant", lk_grant, 0);
         chk("drain_we", tbl_we, 1);
         chk("drain_index", tbl_index, 7'(30 + i));
         chk("drain_ack", sync_ack, 0);
         tick();
      end
      chk("drain_idle_en", tbl_en, 0);
      chk("drain_idle_ack", sync_ack, 0);
      tick();
      chk("ack_high", sync_ack, 1);
      chk("ack_grant", lk_grant, 0);
      chk("ack_stall", stall_f, 1);
      tick();
      chk("post_ack", sync_ack, 0);
      chk("post_grant", lk_grant, 1);
      chk("post_deny", deny_cnt, 8);

      // reset in the middle of a drain with two entries queued
      for (int i = 0; i < 2; i++) begin
         upd(1'b1, 7'(40 + i), 23'd0, 1'b1, 1'b0, 32'd0);
         tick();
      end
      upd(1'b0, 7'd0, 23'd0, 1'b0, 1'b0, 32'd0);
      sync_req = 1'b1;
      tick();
      sync_req = 1'b0;
      #1;
      chk("mid_drain_index", tbl_index, 40);
      chk("mid_drain_grant", lk_grant, 0);
      reset_n = 1'b0;
      #1;
      chk("mrst_grant", lk_grant, 1);
      chk("mrst_index", tbl_index, 3);
      chk("mrst_we", tbl_we, 0);
      chk("mrst_deny", deny_cnt, 0);
      chk("mrst_ack", sync_ack, 0);
      lk_req = 1'b0;
      #1;
      chk("mrst_en", tbl_en, 0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mrst_no_ack", sync_ack, 0);
         chk("mrst_empty", tbl_en, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
